// File: rtl/ucode_pkg.sv
// Shared types and default microcode/dispatch contents for the microcode sequencer.
// The default tables are written for an 8-bit microstate and an 8-bit opcode.
package ucode_pkg;

    localparam int DEF_STATE_W = 8;
    localparam int DEF_CTRL_W  = 16;
    localparam int DEF_OP_W    = 8;
    localparam int DEF_SEL_W   = 3;

    typedef enum logic [1:0] {
        NEXT     = 2'b00,
        JUMP     = 2'b01,
        DISPATCH = 2'b10,
        BRANCH   = 2'b11
    } mode_e;

    // Field order, MSB to LSB, matches the packed microword layout
    typedef struct packed {
        logic [DEF_CTRL_W-1:0]  ctrl;
        logic                   op_en;
        mode_e                  mode;
        logic [DEF_SEL_W-1:0]   cond_sel;
        logic                   cond_pol;
        logic [DEF_STATE_W-1:0] next;
    } uword_t;

    localparam int UWORD_W = $bits(uword_t);

    // fetch_in_dispatch builds the alternate ROM where the dispatch word also fetches
    function automatic uword_t ucode_word(input logic [DEF_STATE_W-1:0] st,
                                          input bit fetch_in_dispatch = 1'b0);
        uword_t w;
        w.ctrl     = '0;
        w.op_en    = 1'b0;
        w.mode     = JUMP;
        w.cond_sel = '0;
        w.cond_pol = 1'b0;
        w.next     = '0;
        case (st)
            8'h00: begin
                w.ctrl  = 16'h0001;
                w.op_en = 1'b1;
                w.next  = 8'h01;
            end
            8'h01: begin
                w.ctrl  = 16'h0002;
                w.mode  = DISPATCH;
                w.op_en = fetch_in_dispatch;
            end
            8'h02: begin
                w.ctrl = 16'h0004;
                w.mode = NEXT;
            end
            8'h03: w.ctrl = 16'h0008;
            8'h04: begin
                w.ctrl     = 16'h0010;
                w.mode     = BRANCH;
                w.cond_sel = 3'd1;
                w.cond_pol = 1'b1;
                w.next     = 8'h00;
            end
            8'h05: w.ctrl = 16'h0020;
            8'hFE: begin
                w.ctrl = 16'h4000;
                w.mode = NEXT;
            end
            8'hFF: begin
                w.ctrl = 16'h8000;
                w.mode = NEXT;
            end
            default: ;
        endcase
        return w;
    endfunction

    // Returns {hit, target}
    function automatic logic [DEF_STATE_W:0] dispatch(input logic [DEF_OP_W-1:0] op);
        logic [DEF_STATE_W:0] r;
        case (op)
            8'h01:   r = {1'b1, 8'h02};
            8'h02:   r = {1'b1, 8'h04};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ucode_sequencer_if.sv
// Bus between the microcode sequencer and the datapath: opcode/flag/stall inputs,
// control word and sequencer status outputs.
interface ucode_sequencer_if #(
    parameter int STATE_W = 8,
    parameter int CTRL_W  = 16,
    parameter int OP_W    = 8,
    parameter int FLAG_W  = 8
);
    logic [OP_W-1:0]    data_in;
    logic [FLAG_W-1:0]  p;
    logic               stall;
    logic [CTRL_W-1:0]  controls;
    logic [STATE_W-1:0] state;
    logic [OP_W-1:0]    opcode;
    logic               illegal;

    modport master (
        output data_in, p, stall,
        input  controls, state, opcode, illegal
    );

    modport slave (
        input  data_in, p, stall,
        output controls, state, opcode, illegal
    );
endinterface

// File: rtl/ucode_rom.sv
// Combinational microcode ROM: unpacks the package microword into fields sized
// for the sequencer's parameters.
module ucode_rom
    import ucode_pkg::*;
#(
    parameter int STATE_W           = 8,
    parameter int CTRL_W            = 16,
    parameter int FLAG_W            = 8,
    parameter bit FETCH_IN_DISPATCH = 1'b0
) (
    input  logic [STATE_W-1:0]                                i_addr,
    output logic [CTRL_W-1:0]                                 o_ctrl,
    output logic                                              o_op_en,
    output mode_e                                             o_mode,
    output logic [((FLAG_W > 1) ? $clog2(FLAG_W) : 1)-1:0]    o_cond_sel,
    output logic                                              o_cond_pol,
    output logic [STATE_W-1:0]                                o_next
);
    localparam int SEL_W = (FLAG_W > 1) ? $clog2(FLAG_W) : 1;

    uword_t w_word;

    // Addresses beyond the 8-bit default table alias onto it
    always_comb begin
        w_word     = ucode_word(DEF_STATE_W'(i_addr), FETCH_IN_DISPATCH);
        o_ctrl     = CTRL_W'(w_word.ctrl);
        o_op_en    = w_word.op_en;
        o_mode     = w_word.mode;
        o_cond_sel = SEL_W'(w_word.cond_sel);
        o_cond_pol = w_word.cond_pol;
        o_next     = STATE_W'(w_word.next);
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: opcode and microstate registers around a combinational ROM,
// with NEXT/JUMP/DISPATCH/BRANCH sequencing, stall and illegal-opcode trapping.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int STATE_W           = 8,
    parameter int CTRL_W            = 16,
    parameter int OP_W              = 8,
    parameter int FLAG_W            = 8,
    parameter int RESET_STATE       = 0,
    parameter int TRAP_STATE        = 2**STATE_W - 1,
    parameter bit FETCH_IN_DISPATCH = 1'b0
) (
    input  logic              ph1,
    input  logic              reset,
    ucode_sequencer_if.slave  bus
);
    localparam int SEL_W = (FLAG_W > 1) ? $clog2(FLAG_W) : 1;

    logic [STATE_W-1:0] r_state;
    logic [OP_W-1:0]    r_opcode;
    logic               r_illegal;

    logic [STATE_W-1:0] w_state_next;
    logic [OP_W-1:0]    w_opcode_next;
    logic               w_illegal_next;

    logic [CTRL_W-1:0]  w_ctrl;
    logic               w_op_en;
    mode_e              w_mode;
    logic [SEL_W-1:0]   w_cond_sel;
    logic               w_cond_pol;
    logic [STATE_W-1:0] w_next;

    logic [STATE_W-1:0] w_state_inc;
    logic [DEF_STATE_W:0] w_disp;
    logic               w_op_fits;
    logic               w_disp_hit;

    ucode_rom #(
        .STATE_W           (STATE_W),
        .CTRL_W            (CTRL_W),
        .FLAG_W            (FLAG_W),
        .FETCH_IN_DISPATCH (FETCH_IN_DISPATCH)
    ) u_rom (
        .i_addr     (r_state),
        .o_ctrl     (w_ctrl),
        .o_op_en    (w_op_en),
        .o_mode     (w_mode),
        .o_cond_sel (w_cond_sel),
        .o_cond_pol (w_cond_pol),
        .o_next     (w_next)
    );

    // Opcodes wider than the dispatch table only hit when their upper bits are zero
    always_comb begin
        w_state_inc = r_state + 1'b1;
        w_disp      = dispatch(DEF_OP_W'(r_opcode));
        w_op_fits   = (OP_W <= DEF_OP_W) || ((r_opcode >> DEF_OP_W) == '0);
        w_disp_hit  = w_disp[DEF_STATE_W] && w_op_fits;
    end

    always_comb begin
        w_state_next   = r_state;
        w_opcode_next  = r_opcode;
        w_illegal_next = r_illegal;
        if (!bus.stall) begin
            w_illegal_next = 1'b0;
            if (w_op_en) begin
                w_opcode_next = bus.data_in;
            end
            unique case (w_mode)
                NEXT: w_state_next = w_state_inc;
                JUMP: w_state_next = w_next;
                DISPATCH: begin
                    if (w_disp_hit) begin
                        w_state_next = STATE_W'(w_disp[DEF_STATE_W-1:0]);
                    end else begin
                        w_state_next   = STATE_W'(TRAP_STATE);
                        w_illegal_next = 1'b1;
                    end
                end
                BRANCH: begin
                    if (bus.p[w_cond_sel] == w_cond_pol) begin
                        w_state_next = w_next;
                    end else begin
                        w_state_next = w_state_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_state   <= STATE_W'(RESET_STATE);
            r_opcode  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_opcode  <= w_opcode_next;
            r_illegal <= w_illegal_next;
        end
    end

    assign bus.controls = w_ctrl;
    assign bus.state    = r_state;
    assign bus.opcode   = r_opcode;
    assign bus.illegal  = r_illegal;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus against a per-state
// behavioural model, for the default ROM and the fetch-in-dispatch ROM build.
module tb_ucode_sequencer;

    logic ph1;
    logic reset;

    ucode_sequencer_if bus   ();
    ucode_sequencer_if bus_a ();

    ucode_sequencer dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    ucode_sequencer #(.FETCH_IN_DISPATCH(1'b1)) dut_a (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus_a)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: index 0 = default ROM, index 1 = fetch-in-dispatch ROM
    int m_st [2];
    int m_op [2];
    int m_ill[2];

    initial begin
        ph1 = 1'b0;
        forever #5 ph1 = ~ph1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_ctrl(input int s);
        case (s)
            0:       return 32'h0001;
            1:       return 32'h0002;
            2:       return 32'h0004;
            3:       return 32'h0008;
            4:       return 32'h0010;
            5:       return 32'h0020;
            254:     return 32'h4000;
            255:     return 32'h8000;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_op[k] = 0; m_ill[k] = 0;
        end
    endtask

    // Behaviour of each microstate of the default program, stated directly
    task automatic model_step(input int k, input int din, input int pp, input bit st);
        int s_n, op_n, ill_n;
        if (st) return;
        s_n = 0; op_n = m_op[k]; ill_n = 0;
        case (m_st[k])
            0: begin op_n = din; s_n = 1; end
            1: begin
                if (k == 1) op_n = din;
                if (m_op[k] == 1)      s_n = 2;
                else if (m_op[k] == 2) s_n = 4;
                else begin s_n = 255; ill_n = 1; end
            end
            2:   s_n = 3;
            3:   s_n = 0;
            4:   s_n = ((pp >> 1) & 1) ? 0 : 5;
            5:   s_n = 0;
            254: s_n = 255;
            255: s_n = 0;
            default: s_n = 0;
        endcase
        m_st[k] = s_n; m_op[k] = op_n; m_ill[k] = ill_n;
    endtask

    task automatic compare_all();
        check_eq("state",    32'(bus.state),      32'(m_st[0]));
        check_eq("controls", 32'(bus.controls),   32'(exp_ctrl(m_st[0])));
        check_eq("opcode",   32'(bus.opcode),     32'(m_op[0]));
        check_eq("illegal",  32'(bus.illegal),    32'(m_ill[0]));
        check_eq("a_state",    32'(bus_a.state),    32'(m_st[1]));
        check_eq("a_controls", 32'(bus_a.controls), 32'(exp_ctrl(m_st[1])));
        check_eq("a_opcode",   32'(bus_a.opcode),   32'(m_op[1]));
        check_eq("a_illegal",  32'(bus_a.illegal),  32'(m_ill[1]));
    endtask

    task automatic drive(input logic [7:0] din, input logic [7:0] pp, input logic st);
        bus.data_in   = din; bus.p   = pp; bus.stall   = st;
        bus_a.data_in = din; bus_a.p = pp; bus_a.stall = st;
    endtask

    // One clock: inputs stay stable across the edge, outputs sampled 1 time unit later
    task automatic tick();
        int din, pp;
        bit st;
        din = int'(bus.data_in);
        pp  = int'(bus.p);
        st  = bus.stall;
        @(posedge ph1);
        #1;
        for (int k = 0; k < 2; k++) model_step(k, din, pp, st);
        compare_all();
        $display("tick din=%02h p=%02h stall=%0d -> state=%02h ctrl=%04h op=%02h ill=%0d | alt state=%02h op=%02h",
                 din, pp, st, bus.state, bus.controls, bus.opcode, bus.illegal,
                 bus_a.state, bus_a.opcode);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq({tag, "_state"},  32'(bus.state),    32'h0);
        check_eq({tag, "_opcode"}, 32'(bus.opcode),   32'h0);
        check_eq({tag, "_ctrl"},   32'(bus.controls), 32'h0001);
        compare_all();
        $display("async reset %s: state=%02h ctrl=%04h op=%02h", tag, bus.state, bus.controls, bus.opcode);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        drive(8'h01, 8'h00, 1'b0);
        model_reset();

        // Reset between edges, before any clock edge has occurred
        #3 reset = 1'b1;
        #1;
        check_eq("rst_state", 32'(bus.state),    32'h0);
        check_eq("rst_ctrl",  32'(bus.controls), 32'h0001);
        check_eq("rst_ill",   32'(bus.illegal),  32'h0);
        compare_all();
        repeat (2) @(posedge ph1);
        #2 reset = 1'b0;

        // Fetch 0x01, dispatch to 2, run back to 0
        tick(); check_eq("seq1_s1", 32'(bus.state), 32'h01);
        tick(); check_eq("seq1_s2", 32'(bus.state), 32'h02); check_eq("seq1_c2", 32'(bus.controls), 32'h0004);
        tick(); check_eq("seq1_s3", 32'(bus.state), 32'h03); check_eq("seq1_c3", 32'(bus.controls), 32'h0008);
        tick(); check_eq("seq1_s0", 32'(bus.state), 32'h00); check_eq("seq1_op", 32'(bus.opcode), 32'h01);

        // Branch taken (p[1]=1) and not taken
        drive(8'h02, 8'h02, 1'b0);
        tick(); tick(); check_eq("br_t_s4", 32'(bus.state), 32'h04);
        tick(); check_eq("br_t_s0", 32'(bus.state), 32'h00);
        drive(8'h02, 8'h00, 1'b0);
        tick(); tick();
        tick(); check_eq("br_n_s5", 32'(bus.state), 32'h05); check_eq("br_n_c5", 32'(bus.controls), 32'h0020);
        tick(); check_eq("br_n_s0", 32'(bus.state), 32'h00);

        // Dispatch miss: trap state, one-cycle illegal, wrap to 0
        drive(8'h37, 8'h00, 1'b0);
        tick();
        tick(); check_eq("trap_s",  32'(bus.state), 32'hFF); check_eq("trap_ill", 32'(bus.illegal), 32'h1);
                check_eq("trap_c",  32'(bus.controls), 32'h8000);
        tick(); check_eq("wrap_s",  32'(bus.state), 32'h00); check_eq("wrap_ill", 32'(bus.illegal), 32'h0);

        // Stall for three cycles at state 1 with data_in changing underneath
        drive(8'h01, 8'h00, 1'b0);
        tick();
        drive(8'h02, 8'h00, 1'b1);
        repeat (3) begin
            tick();
            check_eq("stall_s",  32'(bus.state),    32'h01);
            check_eq("stall_op", 32'(bus.opcode),   32'h01);
            check_eq("stall_c",  32'(bus.controls), 32'h0002);
        end
        drive(8'h02, 8'h00, 1'b0);
        tick(); check_eq("unstall_s", 32'(bus.state), 32'h02);
        tick(); tick();

        // Asynchronous reset while sitting in state 4
        drive(8'h02, 8'h00, 1'b0);
        tick(); tick(); check_eq("pre_rst_s4", 32'(bus.state), 32'h04);
        async_reset_pulse("mid_rst");
        drive(8'h01, 8'h00, 1'b0);
        tick(); check_eq("resume_s1", 32'(bus.state), 32'h01);
        tick(); tick(); tick();

        // Fetch-in-dispatch build dispatches on the previously captured opcode
        drive(8'h01, 8'h00, 1'b0);
        tick();
        drive(8'h02, 8'h00, 1'b0);
        tick();
        check_eq("alt_s",  32'(bus_a.state),  32'h02);
        check_eq("alt_op", 32'(bus_a.opcode), 32'h02);
        check_eq("def_op", 32'(bus.opcode),   32'h01);
        tick(); tick();

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            int sel;
            logic [7:0] din;
            sel = int'($urandom_range(0, 3));
            din = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : 8'($urandom);
            drive(din, 8'($urandom), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 59) == 0) async_reset_pulse("rnd_rst");
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
